onetotwo_demux_stream: RTL



---
 rtl/onetotwo_demux_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/onetotwo_demux_stream.sv
// rtl/onetotwo_demux_stream.sv - registered 1-to-2 stream demux with packet locking (option: ONETOTWO_DEMUX_CNT_EN)
module onetotwo_demux_stream #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out0_data,
  output logic         out0_last,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [W-1:0] out1_data,
  output logic         out1_last,
  output logic         out1_valid,
  input  logic         out1_ready,
  output logic         busy
`ifdef ONETOTWO_DEMUX_CNT_EN
  ,
  output logic [15:0]  cnt0,
  output logic [15:0]  cnt1
`endif
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   lock_sel;
  logic   lock_sel_next;
  logic   target;
  logic   tgt_valid;
  logic   tgt_ready;
  logic   acc;
  logic   load0;
  logic   load1;
  logic   hs0;
  logic   hs1;

  // Routing: the live select only matters on a packet's first beat; in_ready never looks at in_valid
  always_comb begin
    target    = (state == S_LOCKED) ? lock_sel : in_sel;
    tgt_valid = target ? out1_valid : out0_valid;
    tgt_ready = target ? out1_ready : out0_ready;
    in_ready  = !tgt_valid || tgt_ready;
    acc       = in_valid && in_ready;
    load0     = acc && !target;
    load1     = acc && target;
    hs0       = out0_valid && out0_ready;
    hs1       = out1_valid && out1_ready;
  end

  // Packet lock FSM: capture the select on a non-last first beat, release on the last beat
  always_comb begin
    state_next    = state;
    lock_sel_next = lock_sel;
    case (state)
      S_IDLE: begin
        if (acc && !in_last) begin
          lock_sel_next = in_sel;
          state_next    = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (acc && in_last) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM state and locked destination registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lock_sel <= 1'b0;
    end else begin
      state    <= state_next;
      lock_sel <= lock_sel_next;
    end
  end

  assign busy = (state == S_LOCKED);

  // Output 0 slice: a load wins over a drain so simultaneous drain+load leaves no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_data  <= '0;
      out0_last  <= 1'b0;
      out0_valid <= 1'b0;
    end else if (load0) begin
      out0_data  <= in_data;
      out0_last  <= in_last;
      out0_valid <= 1'b1;
    end else if (hs0) begin
      out0_valid <= 1'b0;
    end
  end

  // Output 1 slice: same behaviour as output 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_data  <= '0;
      out1_last  <= 1'b0;
      out1_valid <= 1'b0;
    end else if (load1) begin
      out1_data  <= in_data;
      out1_last  <= in_last;
      out1_valid <= 1'b1;
    end else if (hs1) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef ONETOTWO_DEMUX_CNT_EN
  // Per-output beat counters, free-running with natural 16-bit wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 16'h0000;
      cnt1 <= 16'h0000;
    end else begin
      if (hs0) cnt0 <= cnt0 + 16'h0001;
      if (hs1) cnt1 <= cnt1 + 16'h0001;
    end
  end
`endif

endmodule
